// File: rtl/melody_pkg.sv
// ============================================================================
// Module : melody_pkg
// Brief  : Note encodings, FSM state type and song table for melody_game_ctrl.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package melody_pkg;

   localparam int NOTE_W = 12;

   // One-hot chromatic notes, MSB = C
   localparam logic [11:0] c_note_c  = 12'h800;
   localparam logic [11:0] c_note_cs = 12'h400;
   localparam logic [11:0] c_note_d  = 12'h200;
   localparam logic [11:0] c_note_ds = 12'h100;
   localparam logic [11:0] c_note_e  = 12'h080;
   localparam logic [11:0] c_note_f  = 12'h040;
   localparam logic [11:0] c_note_fs = 12'h020;
   localparam logic [11:0] c_note_g  = 12'h010;
   localparam logic [11:0] c_note_gs = 12'h008;
   localparam logic [11:0] c_note_a  = 12'h004;
   localparam logic [11:0] c_note_as = 12'h002;
   localparam logic [11:0] c_note_b  = 12'h001;

   localparam logic [11:0] c_note_db = c_note_cs;
   localparam logic [11:0] c_note_eb = c_note_ds;
   localparam logic [11:0] c_note_gb = c_note_fs;
   localparam logic [11:0] c_note_ab = c_note_gs;
   localparam logic [11:0] c_note_bb = c_note_as;

   localparam logic [11:0] c_no_note = 12'h000;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LISTEN  = 2'd1,
      ST_ADVANCE = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   localparam int SONG_MAX = 8;

   localparam logic [11:0] c_song_table [SONG_MAX] = '{
      c_note_c, c_note_d, c_note_e, c_note_f,
      c_note_g, c_note_a, c_note_b, c_note_c
   };

   function automatic logic [11:0] song_note(input logic [2:0] idx);
      return c_song_table[idx];
   endfunction

endpackage

`default_nettype wire

// File: rtl/melody_game_ctrl_note_match_timer.sv
// ============================================================================
// Module : note_match_timer
// Brief  : Consecutive-match counter and per-note timeout counter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module note_match_timer #(
   parameter int HOLD_CYCLES    = 2_500_000,
   parameter int TIMEOUT_CYCLES = 100_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   input  logic match,
   output logic hit,
   output logic timeout
);

   localparam int MW = $clog2(HOLD_CYCLES);
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [MW-1:0] c_match_last = MW'(HOLD_CYCLES - 1);
   localparam logic [TW-1:0] c_tmo_last   = TW'(TIMEOUT_CYCLES - 1);

   logic [MW-1:0] r_match_cnt;
   logic [TW-1:0] r_tmo_cnt;
   logic          w_match_term;
   logic          w_tmo_term;

   assign w_match_term = (r_match_cnt == c_match_last);
   assign w_tmo_term   = (r_tmo_cnt == c_tmo_last);
   assign hit          = enable && match && w_match_term;
   assign timeout      = enable && w_tmo_term;

   // Both counters stop at their terminal values instead of wrapping
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         r_match_cnt <= '0;
         r_tmo_cnt   <= '0;
      end else if (enable) begin
         if (!match)
            r_match_cnt <= '0;
         else if (!w_match_term)
            r_match_cnt <= r_match_cnt + MW'(1);
         if (!w_tmo_term)
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
      end
   end

endmodule

`default_nettype wire

// File: rtl/melody_game_ctrl.sv
// ============================================================================
// Module : melody_game_ctrl
// Brief  : Melody-following game FSM with hit/miss scoring.
//          MELODY_GAME_LOOP_EN: wrap to the first note instead of finishing.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module melody_game_ctrl
   import melody_pkg::*;
#(
   parameter int clk_mhz        = 50,
   parameter int w_note         = 12,
   parameter int song_len       = 8,
   parameter int hold_cycles    = 2_500_000,
   parameter int timeout_cycles = 100_000_000
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic                          stop,
   input  logic [w_note-1:0]             detected_note,
   output logic [w_note-1:0]             expected_note,
   output logic [$clog2(song_len)-1:0]   note_index,
   output logic [$clog2(song_len+1)-1:0] hit_cnt,
   output logic [$clog2(song_len+1)-1:0] miss_cnt,
   output logic                          hit_pulse,
   output logic                          miss_pulse,
   output logic                          done,
   output logic [1:0]                    state
);

   localparam int IW = $clog2(song_len);
   localparam int CW = $clog2(song_len + 1);

   state_t        r_state, w_state_nxt;
   logic [IW-1:0] r_idx, w_idx_nxt;
   logic [CW-1:0] r_hit_cnt, w_hit_nxt;
   logic [CW-1:0] r_miss_cnt, w_miss_nxt;
   logic          w_listen, w_match, w_hit, w_timeout;
   logic          w_hit_evt, w_miss_evt, w_room;
   logic [w_note-1:0] w_expected;

   assign w_listen   = (r_state == ST_LISTEN);
   assign w_expected = w_listen ? w_note'(song_note(3'(r_idx))) : '0;
   assign w_match    = (detected_note == w_expected) && (detected_note != '0);

   note_match_timer #(
      .HOLD_CYCLES    (hold_cycles),
      .TIMEOUT_CYCLES (timeout_cycles)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (!w_listen),
      .enable  (w_listen),
      .match   (w_match),
      .hit     (w_hit),
      .timeout (w_timeout)
   );

   // A hit beats a coincident timeout; stop and rst suppress both events
   assign w_hit_evt  = w_listen && w_hit && !stop && !rst;
   assign w_miss_evt = w_listen && w_timeout && !w_hit && !stop && !rst;
   assign w_room     = ({1'b0, r_hit_cnt} + {1'b0, r_miss_cnt}) < (CW+1)'(song_len);

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_hit_nxt   = r_hit_cnt;
      w_miss_nxt  = r_miss_cnt;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               w_state_nxt = ST_LISTEN;
               w_idx_nxt   = '0;
               w_hit_nxt   = '0;
               w_miss_nxt  = '0;
            end
         end
         ST_LISTEN: begin
            if (w_hit_evt) begin
               w_state_nxt = ST_ADVANCE;
               if (w_room) w_hit_nxt = r_hit_cnt + CW'(1);
            end else if (w_miss_evt) begin
               w_state_nxt = ST_ADVANCE;
               if (w_room) w_miss_nxt = r_miss_cnt + CW'(1);
            end
         end
         ST_ADVANCE: begin
            if (r_idx < IW'(song_len - 1)) begin
               w_idx_nxt   = r_idx + IW'(1);
               w_state_nxt = ST_LISTEN;
            end else begin
`ifdef MELODY_GAME_LOOP_EN
               w_idx_nxt   = '0;
               w_hit_nxt   = '0;
               w_miss_nxt  = '0;
               w_state_nxt = ST_LISTEN;
`else
               w_state_nxt = ST_DONE;
`endif
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      if (stop) w_state_nxt = ST_IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_idx      <= '0;
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_idx      <= w_idx_nxt;
         r_hit_cnt  <= w_hit_nxt;
         r_miss_cnt <= w_miss_nxt;
      end
   end

   assign expected_note = w_expected;
   assign note_index    = r_idx;
   assign hit_cnt       = r_hit_cnt;
   assign miss_cnt      = r_miss_cnt;
   assign hit_pulse     = w_hit_evt;
   assign miss_pulse    = w_miss_evt;
   assign state         = r_state;
`ifdef MELODY_GAME_LOOP_EN
   assign done          = 1'b0;
`else
   assign done          = (r_state == ST_DONE);
`endif

endmodule

`default_nettype wire

// File: tb/tb_melody_game_ctrl.sv
// ============================================================================
// Module : tb_melody_game_ctrl
// Brief  : Self-checking bench for melody_game_ctrl (4-note song C,D,E,F).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_melody_game_ctrl;

   localparam int SONG_LEN = 4;
   localparam int HOLD     = 4;
   localparam int TMO      = 20;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic [11:0] detected_note = 12'h000;
   logic [11:0] expected_note;
   logic [1:0]  note_index;
   logic [2:0]  hit_cnt, miss_cnt;
   logic        hit_pulse, miss_pulse, done;
   logic [1:0]  state;

   int errors = 0;
   int checks = 0;

   logic [11:0] song [SONG_LEN] = '{12'h800, 12'h200, 12'h080, 12'h040};

   melody_game_ctrl #(
      .clk_mhz        (50),
      .w_note         (12),
      .song_len       (SONG_LEN),
      .hold_cycles    (HOLD),
      .timeout_cycles (TMO)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .stop          (stop),
      .detected_note (detected_note),
      .expected_note (expected_note),
      .note_index    (note_index),
      .hit_cnt       (hit_cnt),
      .miss_cnt      (miss_cnt),
      .hit_pulse     (hit_pulse),
      .miss_pulse    (miss_pulse),
      .done          (done),
      .state         (state)
   );

   always #5 clk = ~clk;

   // Inputs change 1 ns after the rising edge; outputs are sampled 3 ns later
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; start = 1'b0; stop = 1'b0; detected_note = 12'h000;
      cyc();
      rst = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   task automatic check_idle_outputs(input string tag);
      #3;
      checks++;
      if (state !== 2'd0 || note_index !== 2'd0 || hit_cnt !== 3'd0 || miss_cnt !== 3'd0 ||
          hit_pulse !== 1'b0 || miss_pulse !== 1'b0 || done !== 1'b0 || expected_note !== 12'h000) begin
         errors++;
         $display("FAIL %s: state=%0d idx=%0d hit=%0d miss=%0d hp=%b mp=%b done=%b exp=%h required all zero",
                  tag, state, note_index, hit_cnt, miss_cnt, hit_pulse, miss_pulse, done, expected_note);
      end
   endtask

   // Plays one note perfectly (4 matching cycles) then passes the ADVANCE cycle
   task automatic play_note(input int n);
      detected_note = song[n];
      for (int k = 0; k < HOLD; k++) begin
         #3;
         checks++;
         if (hit_pulse !== (k == HOLD - 1)) begin
            errors++;
            $display("FAIL play_hit n=%0d k=%0d: hit_pulse=%b required %b", n, k, hit_pulse, (k == HOLD - 1));
         end
         cyc();
      end
      detected_note = 12'h000;
      #3;
      checks++;
      if (state !== 2'd2) begin
         errors++;
         $display("FAIL play_advance n=%0d: state=%0d required 2", n, state);
      end
      cyc();
   endtask

   task automatic check_end(input string tag, input int hits, input int misses);
      #3;
      checks++;
`ifdef MELODY_GAME_LOOP_EN
      if (state !== 2'd1 || note_index !== 2'd0 || hit_cnt !== 3'd0 || miss_cnt !== 3'd0 || done !== 1'b0) begin
         errors++;
         $display("FAIL %s_loop: state=%0d idx=%0d hit=%0d miss=%0d done=%b required 1/0/0/0/0",
                  tag, state, note_index, hit_cnt, miss_cnt, done);
      end
`else
      if (state !== 2'd3 || done !== 1'b1 || hit_cnt !== 3'(hits) || miss_cnt !== 3'(misses) ||
          note_index !== 2'd3 || expected_note !== 12'h000) begin
         errors++;
         $display("FAIL %s_end: state=%0d done=%b hit=%0d miss=%0d idx=%0d exp=%h required 3/1/%0d/%0d/3/000",
                  tag, state, done, hit_cnt, miss_cnt, note_index, expected_note, hits, misses);
      end
`endif
   endtask

   task automatic test_reset();
      do_reset();
      check_idle_outputs("reset");
   endtask

   task automatic test_perfect();
      do_reset();
      do_start();
      for (int n = 0; n < SONG_LEN; n++) begin
         #3;
         checks++;
         if (state !== 2'd1 || expected_note !== song[n] || note_index !== 2'(n)) begin
            errors++;
            $display("FAIL perfect_listen n=%0d: state=%0d exp=%h idx=%0d required 1/%h/%0d",
                     n, state, expected_note, note_index, song[n], n);
         end
         play_note(n);
      end
      check_end("perfect", 4, 0);
   endtask

   task automatic test_silence();
      do_reset();
      do_start();
      detected_note = 12'h000;
      for (int c = 0; c < 4 * (TMO + 1); c++) begin
         #3;
         checks++;
         if (miss_pulse !== ((c % (TMO + 1)) == TMO - 1) || hit_pulse !== 1'b0) begin
            errors++;
            $display("FAIL silence c=%0d: miss_pulse=%b hit_pulse=%b required %b 0",
                     c, miss_pulse, hit_pulse, ((c % (TMO + 1)) == TMO - 1));
         end
         cyc();
      end
      check_end("silence", 0, 4);
   endtask

   task automatic test_glitch();
      logic [11:0] pat [8] = '{12'h800, 12'h800, 12'h800, 12'h000, 12'h800, 12'h800, 12'h800, 12'h800};
      do_reset();
      do_start();
      for (int k = 0; k < 8; k++) begin
         detected_note = pat[k];
         #3;
         checks++;
         if (hit_pulse !== (k == 7)) begin
            errors++;
            $display("FAIL glitch k=%0d: hit_pulse=%b required %b", k, hit_pulse, (k == 7));
         end
         cyc();
      end
      detected_note = 12'h000;
      #3;
      checks++;
      if (hit_cnt !== 3'd1 || state !== 2'd2) begin
         errors++;
         $display("FAIL glitch_cnt: hit_cnt=%0d state=%0d required 1 2", hit_cnt, state);
      end
   endtask

   task automatic test_tie();
      do_reset();
      do_start();
      for (int k = 0; k < TMO; k++) begin
         detected_note = (k >= TMO - HOLD) ? song[0] : 12'h000;
         #3;
         checks++;
         if (hit_pulse !== (k == TMO - 1) || miss_pulse !== 1'b0) begin
            errors++;
            $display("FAIL tie k=%0d: hit_pulse=%b miss_pulse=%b required %b 0",
                     k, hit_pulse, miss_pulse, (k == TMO - 1));
         end
         cyc();
      end
      detected_note = 12'h000;
      #3;
      checks++;
      if (hit_cnt !== 3'd1 || miss_cnt !== 3'd0) begin
         errors++;
         $display("FAIL tie_cnt: hit=%0d miss=%0d required 1 0", hit_cnt, miss_cnt);
      end
   endtask

   task automatic test_abort();
      do_reset();
      do_start();
      play_note(0);
      play_note(1);
      #3;
      checks++;
      if (note_index !== 2'd2 || state !== 2'd1) begin
         errors++;
         $display("FAIL abort_pre: idx=%0d state=%0d required 2 1", note_index, state);
      end
      // stop coincides with the 4th matching cycle: no hit may be counted
      detected_note = song[2];
      cyc(); cyc(); cyc();
      stop = 1'b1; start = 1'b1;
      #3;
      checks++;
      if (hit_pulse !== 1'b0) begin
         errors++;
         $display("FAIL abort_hit: hit_pulse=%b required 0", hit_pulse);
      end
      cyc();
      stop = 1'b0; start = 1'b0;
      #3;
      checks++;
      if (state !== 2'd0 || expected_note !== 12'h000 || hit_cnt !== 3'd2) begin
         errors++;
         $display("FAIL abort_stop: state=%0d exp=%h hit=%0d required 0 000 2", state, expected_note, hit_cnt);
      end
      cyc();
      do_start();
      play_note(0);
      detected_note = song[1];
      cyc();
      rst = 1'b1; stop = 1'b1; start = 1'b1;
      cyc();
      rst = 1'b0; stop = 1'b0; start = 1'b0; detected_note = 12'h000;
      check_idle_outputs("abort_rst");
   endtask

   // Random notes and stray start pulses against a per-note outcome model
   task automatic test_random(input int pass);
      int hits = 0;
      int misses = 0;
      logic [11:0] pat [TMO];
      do_reset();
      do_start();
      for (int n = 0; n < SONG_LEN; n++) begin
         int run = 0;
         int ev = TMO - 1;
         bit is_hit = 1'b0;
         for (int k = 0; k < TMO; k++) begin
            int r = int'($urandom_range(0, 3));
            if (r <= 1) pat[k] = song[n];
            else if (r == 2) pat[k] = 12'h000;
            else pat[k] = 12'h001 << $urandom_range(0, 11);
         end
         for (int k = 0; k < TMO; k++) begin
            run = (pat[k] == song[n]) ? run + 1 : 0;
            if (run == HOLD) begin
               ev = k;
               is_hit = 1'b1;
               break;
            end
         end
         if (is_hit) hits++; else misses++;
         for (int k = 0; k <= ev; k++) begin
            detected_note = pat[k];
            start = $urandom_range(0, 1) == 1;
            #3;
            checks++;
            if (hit_pulse !== (k == ev && is_hit) || miss_pulse !== (k == ev && !is_hit) ||
                note_index !== 2'(n)) begin
               errors++;
               $display("FAIL random p=%0d n=%0d k=%0d: hp=%b mp=%b idx=%0d required %b %b %0d",
                        pass, n, k, hit_pulse, miss_pulse, note_index, (k == ev && is_hit),
                        (k == ev && !is_hit), n);
            end
            cyc();
         end
         detected_note = 12'h001 << $urandom_range(0, 11);
         start = $urandom_range(0, 1) == 1;
         #3;
         checks++;
         if (state !== 2'd2 || hit_cnt !== 3'(hits) || miss_cnt !== 3'(misses)) begin
            errors++;
            $display("FAIL random_adv p=%0d n=%0d: state=%0d hit=%0d miss=%0d required 2 %0d %0d",
                     pass, n, state, hit_cnt, miss_cnt, hits, misses);
         end
         cyc();
      end
      start = 1'b0;
      detected_note = 12'h000;
      check_end("random", hits, misses);
   endtask

   initial begin
      test_reset();
      test_perfect();
      test_silence();
      test_glitch();
      test_tie();
      test_abort();
      for (int p = 0; p < 6; p++) test_random(p);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
